spi_ram_arbiter: RTL and testbench

Decodes the SPI slave's 10-bit receive words into RAM commands and shares the single-port RAM between that SPI command stream and a local host request port. It sits between the SPI slave (rx_data/rx_valid in, tx_data/tx_valid out) and the single-port RAM. It owns the write/read address registers, runs round-robin arbitration, and sequences every RAM access with fixed latency.

---
 rtl/spi_ram_arbiter_if.sv | 35 +++
 rtl/spi_ram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_arbiter_if.sv
// Signal bundle between spi_ram_arbiter and its neighbours: SPI slave words, host port and RAM port.
// Names carry the arbiter's point of view (i_ into the arbiter, o_ out of it).
interface spi_ram_arbiter_if #(
  parameter int unsigned W = 8
);
  logic [W+1:0] i_rx_data;
  logic         i_rx_valid;
  logic [W-1:0] o_tx_data;
  logic         o_tx_valid;
  logic         i_host_req;
  logic         i_host_we;
  logic [W-1:0] i_host_addr;
  logic [W-1:0] i_host_wdata;
  logic         o_host_gnt;
  logic         o_host_rvalid;
  logic [W-1:0] o_host_rdata;
  logic         o_ram_en;
  logic         o_ram_we;
  logic [W-1:0] o_ram_addr;
  logic [W-1:0] o_ram_wdata;
  logic [W-1:0] i_ram_rdata;
  logic         o_spi_ovf;

  modport slave (
    input  i_rx_data, i_rx_valid, i_host_req, i_host_we, i_host_addr, i_host_wdata, i_ram_rdata,
    output o_tx_data, o_tx_valid, o_host_gnt, o_host_rvalid, o_host_rdata,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_spi_ovf
  );

  modport master (
    output i_rx_data, i_rx_valid, i_host_req, i_host_we, i_host_addr, i_host_wdata, i_ram_rdata,
    input  o_tx_data, o_tx_valid, o_host_gnt, o_host_rvalid, o_host_rdata,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_spi_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI command words and shares one single-port RAM between the SPI stream and a host port,
// with round-robin arbitration and fixed-latency access sequencing.
module spi_ram_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_ram_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;

  localparam logic [1:0] C_WADDR = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_RADDR = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic [1:0]   r_state,       w_state_nxt;
  logic         r_rx_valid_q;
  logic [W-1:0] r_wr_addr,     w_wr_addr_nxt;
  logic [W-1:0] r_rd_addr,     w_rd_addr_nxt;
  logic         r_spi_pend,    w_spi_pend_nxt;
  logic         r_spi_we,      w_spi_we_nxt;
  logic [W-1:0] r_spi_addr,    w_spi_addr_nxt;
  logic [W-1:0] r_spi_wdata,   w_spi_wdata_nxt;
  logic         r_spi_ovf,     w_spi_ovf_nxt;
  logic         r_last_host,   w_last_host_nxt;
  logic         r_cur_host,    w_cur_host_nxt;
  logic [W-1:0] r_tx_data,     w_tx_data_nxt;
  logic         r_tx_valid,    w_tx_valid_nxt;
  logic         r_host_gnt,    w_host_gnt_nxt;
  logic         r_host_rvalid, w_host_rvalid_nxt;
  logic [W-1:0] r_host_rdata,  w_host_rdata_nxt;
  logic         r_ram_en,      w_ram_en_nxt;
  logic         r_ram_we,      w_ram_we_nxt;
  logic [W-1:0] r_ram_addr,    w_ram_addr_nxt;
  logic [W-1:0] r_ram_wdata,   w_ram_wdata_nxt;

  logic         w_new_word;
  logic [1:0]   w_cmd;
  logic [W-1:0] w_payload;
  logic         w_host_pend;
  logic         w_spi_wins;
  logic         w_host_wins;
  logic         w_grant_spi;

  assign w_new_word  = bus.i_rx_valid & ~r_rx_valid_q;
  assign w_cmd       = bus.i_rx_data[W+1:W];
  assign w_payload   = bus.i_rx_data[W-1:0];
  assign w_host_pend = bus.i_host_req & ~((r_state != S_IDLE) & r_cur_host);
  // On a tie the requester that did not win last time goes first.
  assign w_spi_wins  = r_spi_pend & (~w_host_pend | r_last_host);
  assign w_host_wins = w_host_pend & (~r_spi_pend | ~r_last_host);
  assign w_grant_spi = (r_state == S_IDLE) & w_spi_wins;

  // Next-state, arbitration and command decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_wr_addr_nxt     = r_wr_addr;
    w_rd_addr_nxt     = r_rd_addr;
    w_spi_pend_nxt    = r_spi_pend;
    w_spi_we_nxt      = r_spi_we;
    w_spi_addr_nxt    = r_spi_addr;
    w_spi_wdata_nxt   = r_spi_wdata;
    w_spi_ovf_nxt     = r_spi_ovf;
    w_last_host_nxt   = r_last_host;
    w_cur_host_nxt    = r_cur_host;
    w_tx_data_nxt     = r_tx_data;
    w_tx_valid_nxt    = r_tx_valid;
    w_host_gnt_nxt    = 1'b0;
    w_host_rvalid_nxt = 1'b0;
    w_host_rdata_nxt  = r_host_rdata;
    w_ram_en_nxt      = 1'b0;
    w_ram_we_nxt      = 1'b0;
    w_ram_addr_nxt    = r_ram_addr;
    w_ram_wdata_nxt   = r_ram_wdata;

    if (w_new_word) w_tx_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_spi_wins) begin
          w_state_nxt     = S_ACCESS;
          w_ram_en_nxt    = 1'b1;
          w_ram_we_nxt    = r_spi_we;
          w_ram_addr_nxt  = r_spi_addr;
          if (r_spi_we) w_ram_wdata_nxt = r_spi_wdata;
          w_spi_pend_nxt  = 1'b0;
          w_cur_host_nxt  = 1'b0;
          w_last_host_nxt = 1'b0;
        end else if (w_host_wins) begin
          w_state_nxt     = S_ACCESS;
          w_ram_en_nxt    = 1'b1;
          w_ram_we_nxt    = bus.i_host_we;
          w_ram_addr_nxt  = bus.i_host_addr;
          if (bus.i_host_we) w_ram_wdata_nxt = bus.i_host_wdata;
          w_host_gnt_nxt  = 1'b1;
          w_cur_host_nxt  = 1'b1;
          w_last_host_nxt = 1'b1;
        end
      end
      S_ACCESS: w_state_nxt = r_ram_we ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: begin
        w_state_nxt = S_IDLE;
        if (r_cur_host) begin
          w_host_rdata_nxt  = bus.i_ram_rdata;
          w_host_rvalid_nxt = 1'b1;
        end else begin
          w_tx_data_nxt  = bus.i_ram_rdata;
          w_tx_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Data commands snapshot the address now; capture on a grant edge replaces nothing.
    if (w_new_word) begin
      case (w_cmd)
        C_WADDR: w_wr_addr_nxt = w_payload;
        C_WRITE: begin
          if (r_spi_pend && !w_grant_spi) w_spi_ovf_nxt = 1'b1;
          w_spi_pend_nxt  = 1'b1;
          w_spi_we_nxt    = 1'b1;
          w_spi_addr_nxt  = r_wr_addr;
          w_spi_wdata_nxt = w_payload;
        end
        C_RADDR: w_rd_addr_nxt = w_payload;
        C_READ: begin
          if (r_spi_pend && !w_grant_spi) w_spi_ovf_nxt = 1'b1;
          w_spi_pend_nxt = 1'b1;
          w_spi_we_nxt   = 1'b0;
          w_spi_addr_nxt = r_rd_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_rx_valid_q  <= 1'b0;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_spi_pend    <= 1'b0;
      r_spi_we      <= 1'b0;
      r_spi_addr    <= '0;
      r_spi_wdata   <= '0;
      r_spi_ovf     <= 1'b0;
      r_last_host   <= 1'b1;
      r_cur_host    <= 1'b0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_wdata   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rx_valid_q  <= bus.i_rx_valid;
      r_wr_addr     <= w_wr_addr_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
      r_spi_pend    <= w_spi_pend_nxt;
      r_spi_we      <= w_spi_we_nxt;
      r_spi_addr    <= w_spi_addr_nxt;
      r_spi_wdata   <= w_spi_wdata_nxt;
      r_spi_ovf     <= w_spi_ovf_nxt;
      r_last_host   <= w_last_host_nxt;
      r_cur_host    <= w_cur_host_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_valid    <= w_tx_valid_nxt;
      r_host_gnt    <= w_host_gnt_nxt;
      r_host_rvalid <= w_host_rvalid_nxt;
      r_host_rdata  <= w_host_rdata_nxt;
      r_ram_en      <= w_ram_en_nxt;
      r_ram_we      <= w_ram_we_nxt;
      r_ram_addr    <= w_ram_addr_nxt;
      r_ram_wdata   <= w_ram_wdata_nxt;
    end
  end

  assign bus.o_tx_data     = r_tx_data;
  assign bus.o_tx_valid    = r_tx_valid;
  assign bus.o_host_gnt    = r_host_gnt;
  assign bus.o_host_rvalid = r_host_rvalid;
  assign bus.o_host_rdata  = r_host_rdata;
  assign bus.o_ram_en      = r_ram_en;
  assign bus.o_ram_we      = r_ram_we;
  assign bus.o_ram_addr    = r_ram_addr;
  assign bus.o_ram_wdata   = r_ram_wdata;
  assign bus.o_spi_ovf     = r_spi_ovf;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: stimulus pushes expected RAM accesses and read data,
// a negedge monitor pops and compares whenever the DUT presents an access or a read result.
module tb_spi_ram_arbiter;

  typedef struct packed {
    logic       host;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ram_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  ram_exp_t   ram_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] hrd_q[$];
  ram_exp_t   e;
  logic [7:0] d;
  logic       prev_tx = 1'b0;
  logic [7:0] mem [256];

  spi_ram_arbiter_if #(.W(8)) bus ();

  spi_ram_arbiter #(.W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM model: read data valid the cycle after ram_en is sampled.
  always @(posedge clk) begin
    if (bus.o_ram_en) begin
      if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
      else              bus.i_ram_rdata     <= mem[bus.o_ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every DUT-presented event must match the head of its queue.
  always @(negedge clk) begin
    if (bus.o_ram_en) begin
      if (ram_q.size() == 0) check("ram_access_unexpected", 32'd1, 32'd0);
      else begin
        e = ram_q.pop_front();
        check("ram_we", 32'(bus.o_ram_we), 32'(e.we));
        check("ram_addr", 32'(bus.o_ram_addr), 32'(e.addr));
        if (e.we) check("ram_wdata", 32'(bus.o_ram_wdata), 32'(e.wdata));
        check("host_gnt_with_access", 32'(bus.o_host_gnt), 32'(e.host));
      end
    end else if (bus.o_host_gnt) begin
      check("host_gnt_without_access", 32'd1, 32'd0);
    end
    if (bus.o_host_rvalid) begin
      if (hrd_q.size() == 0) check("host_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        d = hrd_q.pop_front();
        check("host_rdata", 32'(bus.o_host_rdata), 32'(d));
      end
    end
    if (bus.o_tx_valid && !prev_tx) begin
      if (tx_q.size() == 0) check("tx_valid_unexpected", 32'd1, 32'd0);
      else begin
        d = tx_q.pop_front();
        check("tx_data", 32'(bus.o_tx_data), 32'(d));
      end
    end
    prev_tx = bus.o_tx_valid;
  end

  // Advance to following negedges; the host drops its request once it sees host_gnt.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.o_host_gnt) bus.i_host_req = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [9:0] w);
    tick(1);
    bus.i_rx_data  = w;
    bus.i_rx_valid = 1'b1;
    tick(1);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic host_issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bus.i_host_we    = we;
    bus.i_host_addr  = addr;
    bus.i_host_wdata = wdata;
    bus.i_host_req   = 1'b1;
  endtask

  task automatic wait_host_done(input int budget);
    for (int i = 0; i < budget && bus.i_host_req; i++) tick(1);
    check("host_gnt_within_budget", 32'(bus.i_host_req), 32'd0);
  endtask

  task automatic push_ram(input logic host, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    ram_q.push_back('{host: host, we: we, addr: addr, wdata: wdata});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_valid"},    32'(bus.o_tx_valid),    32'd0);
    check({tag, "_tx_data"},     32'(bus.o_tx_data),     32'd0);
    check({tag, "_host_gnt"},    32'(bus.o_host_gnt),    32'd0);
    check({tag, "_host_rvalid"}, 32'(bus.o_host_rvalid), 32'd0);
    check({tag, "_host_rdata"},  32'(bus.o_host_rdata),  32'd0);
    check({tag, "_ram_en"},      32'(bus.o_ram_en),      32'd0);
    check({tag, "_ram_we"},      32'(bus.o_ram_we),      32'd0);
    check({tag, "_ram_addr"},    32'(bus.o_ram_addr),    32'd0);
    check({tag, "_ram_wdata"},   32'(bus.o_ram_wdata),   32'd0);
    check({tag, "_spi_ovf"},     32'(bus.o_spi_ovf),     32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_rx_data    = '0;
    bus.i_rx_valid   = 1'b0;
    bus.i_host_req   = 1'b0;
    bus.i_host_we    = 1'b0;
    bus.i_host_addr  = '0;
    bus.i_host_wdata = '0;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;

    // Host write seeds mem[0x10] = 0xA5 for later host reads.
    push_ram(1'b1, 1'b1, 8'h10, 8'hA5);
    host_issue(1'b1, 8'h10, 8'hA5);
    wait_host_done(10);
    tick(3);

    // SPI write path.
    push_ram(1'b0, 1'b1, 8'h2A, 8'h5C);
    spi_word(10'h02A);
    spi_word(10'h15C);
    tick(4);
    check("tx_valid_after_write", 32'(bus.o_tx_valid), 32'd0);

    // SPI read path: tx_valid exactly three edges after capture, cleared by the next word.
    push_ram(1'b0, 1'b0, 8'h2A, 8'h00);
    tx_q.push_back(8'h5C);
    spi_word(10'h22A);
    spi_word(10'h300);
    tick(2);
    check("tx_valid_early", 32'(bus.o_tx_valid), 32'd0);
    tick(1);
    check("tx_valid_latency", 32'(bus.o_tx_valid), 32'd1);
    check("tx_data_direct", 32'(bus.o_tx_data), 32'h5C);
    spi_word(10'h040);
    check("tx_valid_cleared", 32'(bus.o_tx_valid), 32'd0);

    // Level-held rx_valid produces a single write.
    push_ram(1'b0, 1'b1, 8'h40, 8'h11);
    tick(1);
    bus.i_rx_data  = 10'h111;
    bus.i_rx_valid = 1'b1;
    tick(5);
    bus.i_rx_valid = 1'b0;
    tick(5);
    check("ovf_after_level", 32'(bus.o_spi_ovf), 32'd0);

    // Contention after reset: first tie goes to SPI.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    push_ram(1'b0, 1'b1, 8'h00, 8'h77);
    push_ram(1'b1, 1'b0, 8'h10, 8'h00);
    hrd_q.push_back(8'hA5);
    spi_word(10'h177);
    host_issue(1'b0, 8'h10, 8'h00);
    wait_host_done(10);
    tick(4);

    // Host won last, so the next tie goes to SPI again.
    push_ram(1'b0, 1'b1, 8'h00, 8'h88);
    push_ram(1'b1, 1'b1, 8'h20, 8'h99);
    spi_word(10'h188);
    host_issue(1'b1, 8'h20, 8'h99);
    wait_host_done(10);
    tick(2);

    // SPI wins alone, then the following tie goes to the host.
    push_ram(1'b0, 1'b1, 8'h00, 8'h33);
    spi_word(10'h133);
    tick(3);
    push_ram(1'b1, 1'b1, 8'h21, 8'h55);
    push_ram(1'b0, 1'b1, 8'h00, 8'h44);
    spi_word(10'h144);
    host_issue(1'b1, 8'h21, 8'h55);
    wait_host_done(10);
    tick(4);
    check("ovf_before_overflow", 32'(bus.o_spi_ovf), 32'd0);

    // Overflow: two SPI writes captured while a host read occupies the RAM.
    push_ram(1'b1, 1'b0, 8'h10, 8'h00);
    hrd_q.push_back(8'hA5);
    push_ram(1'b0, 1'b1, 8'h00, 8'h02);
    tick(1);
    host_issue(1'b0, 8'h10, 8'h00);
    bus.i_rx_data  = 10'h101;
    bus.i_rx_valid = 1'b1;
    tick(1);
    bus.i_rx_valid = 1'b0;
    tick(1);
    bus.i_rx_data  = 10'h102;
    bus.i_rx_valid = 1'b1;
    tick(1);
    bus.i_rx_valid = 1'b0;
    check("spi_ovf_set", 32'(bus.o_spi_ovf), 32'd1);
    tick(6);
    check("spi_ovf_sticky", 32'(bus.o_spi_ovf), 32'd1);

    // Reset during RD_WAIT of a host read: no host_rvalid, everything back to zero.
    spi_word(10'h050);
    tick(2);
    push_ram(1'b1, 1'b0, 8'h10, 8'h00);
    host_issue(1'b0, 8'h10, 8'h00);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_all_zero("rst_rdwait");
    rst = 1'b0;
    tick(1);

    // Address registers were cleared: write and read both land at 0x00.
    push_ram(1'b0, 1'b1, 8'h00, 8'h66);
    spi_word(10'h166);
    tick(3);
    push_ram(1'b0, 1'b0, 8'h00, 8'h00);
    tx_q.push_back(8'h66);
    spi_word(10'h300);
    tick(5);

    check("ram_q_drained", 32'(ram_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check("hrd_q_drained", 32'(hrd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
